add_round_key_pipe: RTL and testbench
=====================================

Name: add_round_key_pipe

Overview:
Registered, flow-controlled AddRoundKey stage for the AES128 datapath. It holds a bank of up to NUM_KEYS round keys, each with its own valid flag. Each accepted block is XORed with the round key selected by a per-block index. The block sits between the round-key expansion logic (key write port) and the round pipeline (data ports), and supports backpressure on the output side.

Parameters:
DATA_WIDTH, 128, width of data block and of each round key in bits
NUM_KEYS, 11, number of round-key entries in the bank (rounds 0..10 for AES-128)
KEY_IDX_W, 4, width of key index ports; must satisfy 2**KEY_IDX_W >= NUM_KEYS

Ports:
clk  input  1  single clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
key_wr_en  input  1  write key_wr_data into entry key_wr_idx this cycle
key_wr_idx  input  KEY_IDX_W  target key entry
key_wr_data  input  DATA_WIDTH  round key value
key_clr  input  1  invalidate all key entries (zeroise)
data_in  input  DATA_WIDTH  state block to be keyed
data_in_idx  input  KEY_IDX_W  round-key entry to apply to data_in
data_in_vld  input  1  data_in/data_in_idx valid
data_in_rdy  output  1  block can accept data_in this cycle
block_data_out  output  DATA_WIDTH  keyed block
block_data_out_vld  output  1  block_data_out valid
block_data_out_rdy  input  1  downstream accepts block_data_out
block_data_out_err  output  1  qualifies the current output: selected key was invalid or out of range

Behaviour:
- Reset (async assert, sync use on next edge): key entries = 0; key valid flags = 0; block_data_out = 0; block_data_out_vld = 0; block_data_out_err = 0.
- Key bank:
  - key_wr_en with key_wr_idx < NUM_KEYS: entry <= key_wr_data and its valid flag <= 1 at the next edge.
  - key_wr_idx >= NUM_KEYS: the write is ignored; no state change.
  - key_clr: all entries <= 0 and all valid flags <= 0. key_clr has priority over key_wr_en in the same cycle.
- Handshake:
  - data_in_rdy = !block_data_out_vld || block_data_out_rdy (combinational from output state).
  - Transfer in occurs when data_in_vld && data_in_rdy. Transfer out occurs when block_data_out_vld && block_data_out_rdy.
- Datapath: one output register; latency 1 cycle from accept to block_data_out_vld. Full throughput (one block per cycle) while block_data_out_rdy = 1.
- On accept:
  - If data_in_idx < NUM_KEYS and that entry is valid: block_data_out <= data_in ^ key[data_in_idx]; err <= 0.
  - Otherwise: block_data_out <= 0; err <= 1; block_data_out_vld <= 1 (the error is reported, not dropped).
- Stall: while block_data_out_vld && !block_data_out_rdy, block_data_out, block_data_out_vld and block_data_out_err hold stable and data_in_rdy = 0.
- Drain: on a transfer out with no accept in the same cycle, block_data_out_vld <= 0. block_data_out keeps its last value.
- Simultaneous transfer out and accept: output reloads with the new block; vld stays 1.
- Key write or clear in the same cycle as an accept that uses the same entry: the accept uses the pre-edge key and valid flag. The new value affects only later accepts.
- A key write or clear never alters a block already held in the output register.
- rst asserted mid-stall: the pending output is discarded and all state returns to reset values.

Optional Feature:
Macro ARK_PASS_THROUGH_EN.
- Defined: an invalid or out-of-range key selection outputs block_data_out = data_in unmodified, with err = 1.
- Not defined: the block outputs all zeros with err = 1, as described above.
- Handshake and latency are identical in both builds.

Test Plan:
- Reset, write key[0]=0x000102030405060708090a0b0c0d0e0f, send data 0x00112233445566778899aabbccddeeff idx 0, rdy=1 -> next cycle out=0x00102030405060708090a0b0c0d0e0f0, vld=1, err=0.
- Stream idx 0..10 back-to-back with all keys loaded and out_rdy=1 -> 11 outputs on 11 consecutive cycles, each data^key[i], data_in_rdy never drops.
- Hold block_data_out_rdy=0 for 3 cycles after one accept -> output stable for 3 cycles, data_in_rdy=0, second block then accepted on the cycle out_rdy returns to 1.
- Send idx 5 with key[5] never written, and idx 12 -> out=0 (or data_in with ARK_PASS_THROUGH_EN), err=1, vld=1.
- Same cycle: key_wr_en idx 2 new value, key_clr=1, accept idx 2 (old valid key) -> output uses old key[2], err=0. Next accept idx 2 -> err=1 (clr wins).
- Assert rst while output stalled with vld=1 -> vld=0, out=0, err=0 immediately. After release, idx 0 accept -> err=1 (keys cleared).

Source files
------------

// File: rtl/add_round_key_pipe.sv
// Registered AddRoundKey stage: round-key bank with per-entry valid flags and one flow-controlled output register.
// Build option ARK_PASS_THROUGH_EN: an invalid/out-of-range key selection passes data_in through (err=1) instead of zeros.
module add_round_key_pipe #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_KEYS   = 11,
  parameter int KEY_IDX_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_wr_en,
  input  logic [KEY_IDX_W-1:0]  key_wr_idx,
  input  logic [DATA_WIDTH-1:0] key_wr_data,
  input  logic                  key_clr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [KEY_IDX_W-1:0]  data_in_idx,
  input  logic                  data_in_vld,
  output logic                  data_in_rdy,
  output logic [DATA_WIDTH-1:0] block_data_out,
  output logic                  block_data_out_vld,
  input  logic                  block_data_out_rdy,
  output logic                  block_data_out_err
);

  logic [DATA_WIDTH-1:0] key_q [NUM_KEYS];
  logic [DATA_WIDTH-1:0] key_d [NUM_KEYS];
  logic [NUM_KEYS-1:0]   key_vld_q, key_vld_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  vld_q, vld_d;
  logic                  err_q, err_d;

  logic                  key_hit;
  logic [DATA_WIDTH-1:0] key_sel;
  logic                  accept;

  // Lookup uses the pre-edge bank, so same-cycle writes/clears only affect later blocks.
  always_comb begin
    key_hit = 1'b0;
    key_sel = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (data_in_idx == KEY_IDX_W'(i) && key_vld_q[i]) begin
        key_hit = 1'b1;
        key_sel = key_q[i];
      end
    end
  end

  always_comb begin
    key_d     = key_q;
    key_vld_d = key_vld_q;
    if (key_clr) begin
      for (int i = 0; i < NUM_KEYS; i++) key_d[i] = '0;
      key_vld_d = '0;
    end else if (key_wr_en) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_wr_idx == KEY_IDX_W'(i)) begin
          key_d[i]     = key_wr_data;
          key_vld_d[i] = 1'b1;
        end
      end
    end
  end

  assign data_in_rdy = !vld_q || block_data_out_rdy;
  assign accept      = data_in_vld && data_in_rdy;

  always_comb begin
    out_d = out_q;
    vld_d = vld_q;
    err_d = err_q;
    if (accept) begin
      vld_d = 1'b1;
      if (key_hit) begin
        out_d = data_in ^ key_sel;
        err_d = 1'b0;
      end else begin
`ifdef ARK_PASS_THROUGH_EN
        out_d = data_in;
`else
        out_d = '0;
`endif
        err_d = 1'b1;
      end
    end else if (vld_q && block_data_out_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q     <= '{default: '0};
      key_vld_q <= '0;
      out_q     <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      key_q     <= key_d;
      key_vld_q <= key_vld_d;
      out_q     <= out_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
    end
  end

  assign block_data_out     = out_q;
  assign block_data_out_vld = vld_q;
  assign block_data_out_err = err_q;

endmodule

// File: tb/tb_add_round_key_pipe.sv
// Self-checking bench for add_round_key_pipe: directed vector table, handshake corner sequences,
// then randomized traffic against a key-bank/scoreboard reference model.
module tb_add_round_key_pipe;
  localparam int DW = 128;
  localparam int NK = 11;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_wr_en;
  logic [IW-1:0] key_wr_idx;
  logic [DW-1:0] key_wr_data;
  logic          key_clr;
  logic [DW-1:0] data_in;
  logic [IW-1:0] data_in_idx;
  logic          data_in_vld;
  logic          data_in_rdy;
  logic [DW-1:0] block_data_out;
  logic          block_data_out_vld;
  logic          block_data_out_rdy;
  logic          block_data_out_err;

  add_round_key_pipe #(.DATA_WIDTH(DW), .NUM_KEYS(NK), .KEY_IDX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data), .key_clr(key_clr),
    .data_in(data_in), .data_in_idx(data_in_idx), .data_in_vld(data_in_vld), .data_in_rdy(data_in_rdy),
    .block_data_out(block_data_out), .block_data_out_vld(block_data_out_vld),
    .block_data_out_rdy(block_data_out_rdy), .block_data_out_err(block_data_out_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // What an error output should carry for a given input block.
  function automatic logic [DW-1:0] bad_out(input logic [DW-1:0] d);
`ifdef ARK_PASS_THROUGH_EN
    return d;
`else
    return '0;
`endif
  endfunction

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic [DW-1:0] exp_out;
    logic          exp_err;
  } vec_t;

  vec_t          tbl [12];
  logic [DW-1:0] kval [NK];

  // Reference model state for the random phase.
  logic [DW-1:0] m_key [NK];
  bit            m_vld [NK];
  typedef struct { logic [DW-1:0] out; logic err; } exp_t;
  exp_t          sb [$];

  task automatic idle_inputs();
    key_wr_en = 0; key_wr_idx = '0; key_wr_data = '0; key_clr = 0;
    data_in = '0; data_in_idx = '0; data_in_vld = 0; block_data_out_rdy = 1;
  endtask

  task automatic write_key(input int i, input logic [DW-1:0] v);
    @(negedge clk);
    key_wr_en = 1; key_wr_idx = IW'(i); key_wr_data = v;
    @(negedge clk);
    key_wr_en = 0;
  endtask

  logic [DW-1:0] da, db, old2;
  exp_t          e;
  int            outs_seen;
  bit            hit;
  logic [DW-1:0] exp_o;

  initial begin
    idle_inputs();
    rst = 1;
    #12;
    chk("reset_vld", {127'd0, block_data_out_vld}, '0);
    chk("reset_out", block_data_out, '0);
    chk("reset_err", {127'd0, block_data_out_err}, '0);
    @(negedge clk);
    rst = 0;

    // ---------------- table-driven vectors ----------------
    kval[0] = 128'h000102030405060708090a0b0c0d0e0f;
    for (int i = 1; i < NK; i++) kval[i] = {$urandom, $urandom, $urandom, $urandom};
    tbl[0].data = 128'h00112233445566778899aabbccddeeff;
    tbl[0].idx = 0;
    tbl[0].exp_out = 128'h00102030405060708090a0b0c0d0e0f0;
    tbl[0].exp_err = 0;
    for (int i = 0; i < NK; i++) begin
      tbl[i+1].data    = {$urandom, $urandom, $urandom, $urandom};
      tbl[i+1].idx     = IW'(i);
      tbl[i+1].exp_out = tbl[i+1].data ^ kval[i];
      tbl[i+1].exp_err = 0;
    end
    for (int i = 0; i < NK; i++) write_key(i, kval[i]);

    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("tbl%0d_out", i-1), block_data_out, tbl[i-1].exp_out);
        chk($sformatf("tbl%0d_vld_err", i-1), {126'd0, block_data_out_vld, block_data_out_err},
            {126'd0, 1'b1, tbl[i-1].exp_err});
      end
      if (i < 12) begin
        data_in = tbl[i].data; data_in_idx = tbl[i].idx; data_in_vld = 1;
        #1 chk($sformatf("tbl%0d_in_rdy", i), {127'd0, data_in_rdy}, 128'd1);
      end else begin
        data_in_vld = 0;
      end
    end
    @(negedge clk);
    chk("drain_vld", {127'd0, block_data_out_vld}, '0);
    chk("drain_keeps_out", block_data_out, tbl[11].exp_out);

    // ---------------- stall for 3 cycles ----------------
    da = {$urandom, $urandom, $urandom, $urandom};
    db = {$urandom, $urandom, $urandom, $urandom};
    data_in = da; data_in_idx = 3; data_in_vld = 1; block_data_out_rdy = 0;
    @(negedge clk);
    data_in = db; data_in_idx = 4;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d_out", c), block_data_out, da ^ kval[3]);
      chk($sformatf("stall%0d_vld", c), {127'd0, block_data_out_vld}, 128'd1);
      chk($sformatf("stall%0d_in_rdy", c), {127'd0, data_in_rdy}, '0);
      @(negedge clk);
    end
    block_data_out_rdy = 1;
    #1 chk("unstall_in_rdy", {127'd0, data_in_rdy}, 128'd1);
    @(negedge clk);
    data_in_vld = 0;
    chk("after_stall_out", block_data_out, db ^ kval[4]);
    chk("after_stall_vld", {127'd0, block_data_out_vld}, 128'd1);
    @(negedge clk);

    // ---------------- same-cycle write + clear + accept ----------------
    old2 = kval[2];
    da = {$urandom, $urandom, $urandom, $urandom};
    key_wr_en = 1; key_wr_idx = 2; key_wr_data = ~old2; key_clr = 1;
    data_in = da; data_in_idx = 2; data_in_vld = 1;
    @(negedge clk);
    key_wr_en = 0; key_clr = 0;
    chk("clr_same_cycle_out", block_data_out, da ^ old2);
    chk("clr_same_cycle_err", {127'd0, block_data_out_err}, '0);
    db = {$urandom, $urandom, $urandom, $urandom};
    data_in = db;
    @(negedge clk);
    chk("after_clr_out", block_data_out, bad_out(db));
    chk("after_clr_err", {126'd0, block_data_out_vld, block_data_out_err}, 128'd3);

    // ---------------- unwritten and out-of-range keys ----------------
    write_key(0, kval[0]);
    da = {$urandom, $urandom, $urandom, $urandom};
    data_in = da; data_in_idx = 5; data_in_vld = 1;
    @(negedge clk);
    chk("unwritten_out", block_data_out, bad_out(da));
    chk("unwritten_err", {126'd0, block_data_out_vld, block_data_out_err}, 128'd3);
    data_in_idx = 12;
    @(negedge clk);
    chk("oor_out", block_data_out, bad_out(da));
    chk("oor_err", {126'd0, block_data_out_vld, block_data_out_err}, 128'd3);
    data_in_idx = 0;
    @(negedge clk);
    chk("key0_ok_out", block_data_out, da ^ kval[0]);
    chk("key0_ok_err", {127'd0, block_data_out_err}, '0);

    // ---------------- reset during stall ----------------
    block_data_out_rdy = 0;
    @(negedge clk);
    data_in_vld = 0;
    chk("prereset_vld", {127'd0, block_data_out_vld}, 128'd1);
    rst = 1;
    #1;
    chk("midreset_vld", {127'd0, block_data_out_vld}, '0);
    chk("midreset_out", block_data_out, '0);
    chk("midreset_err", {127'd0, block_data_out_err}, '0);
    @(negedge clk);
    rst = 0; block_data_out_rdy = 1;
    data_in = da; data_in_idx = 0; data_in_vld = 1;
    @(negedge clk);
    data_in_vld = 0;
    chk("postreset_out", block_data_out, bad_out(da));
    chk("postreset_err", {126'd0, block_data_out_vld, block_data_out_err}, 128'd3);
    @(negedge clk);

    // ---------------- randomized traffic vs. reference model ----------------
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < NK; i++) begin m_key[i] = '0; m_vld[i] = 0; end
    sb.delete();
    outs_seen = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      key_wr_en          = ($urandom_range(0, 3) == 0);
      key_wr_idx         = IW'($urandom_range(0, 15));
      key_wr_data        = {$urandom, $urandom, $urandom, $urandom};
      key_clr            = ($urandom_range(0, 63) == 0);
      data_in            = {$urandom, $urandom, $urandom, $urandom};
      data_in_idx        = IW'($urandom_range(0, 13));
      data_in_vld        = ($urandom_range(0, 3) != 0);
      block_data_out_rdy = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_in_rdy", {127'd0, data_in_rdy}, {127'd0, !block_data_out_vld || block_data_out_rdy});
      chk("rnd_vld_tracks_sb", {127'd0, block_data_out_vld}, {127'd0, sb.size() != 0});
      if (block_data_out_vld && sb.size() != 0) begin
        chk("rnd_out", block_data_out, sb[0].out);
        chk("rnd_err", {127'd0, block_data_out_err}, {127'd0, sb[0].err});
        if (block_data_out_rdy) begin
          void'(sb.pop_front());
          outs_seen++;
        end
      end
      if (data_in_vld && data_in_rdy) begin
        hit = (data_in_idx < NK) && m_vld[data_in_idx];
        exp_o = hit ? (data_in ^ m_key[data_in_idx]) : bad_out(data_in);
        e.out = exp_o;
        e.err = !hit;
        sb.push_back(e);
      end
      if (key_clr) begin
        for (int i = 0; i < NK; i++) begin m_key[i] = '0; m_vld[i] = 0; end
      end else if (key_wr_en && key_wr_idx < NK) begin
        m_key[key_wr_idx] = key_wr_data;
        m_vld[key_wr_idx] = 1;
      end
    end
    @(negedge clk);
    data_in_vld = 0; block_data_out_rdy = 1; key_wr_en = 0; key_clr = 0;
    checks++;
    if (outs_seen < 500) begin
      errors++;
      $display("FAIL rnd_throughput: got %0d outputs expected at least 500", outs_seen);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
